// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue and the fetch/translate logic.
// Window byte order: byte i of the 48-bit window occupies bits [8*i +: 8] and
// holds the byte at address win_pc + i (byte 0 = lowest address).
package inst_prefetch_queue_pkg;

    localparam int unsigned INST_WIN_BYTES = 6;
    localparam int unsigned INST_LEN_W     = 3;
    localparam int unsigned INST_WIN_W     = INST_WIN_BYTES * 8;

    // Bit offset of window byte idx.
    function automatic int unsigned win_lsb(input int unsigned idx);
        return idx * 8;
    endfunction

endpackage

// File: rtl/inst_prefetch_queue_byte_window_rotate.sv
// Combinational window extraction for the prefetch queue.
// Ports:
//   i_buf        flattened DEPTH-byte circular buffer, slot k at [8*k +: 8]
//   i_head       index of the oldest byte
//   i_count      number of valid bytes in the buffer
//   o_win_bytes  oldest up-to-6 bytes, byte 0 = oldest; invalid bytes read 0
//   o_win_count  min(i_count, 6)
module inst_prefetch_queue_byte_window_rotate
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = PTR_W + 1
) (
    input  logic [DEPTH*8-1:0]      i_buf,
    input  logic [PTR_W-1:0]        i_head,
    input  logic [CNT_W-1:0]        i_count,
    output logic [INST_WIN_W-1:0]   o_win_bytes,
    output logic [INST_LEN_W-1:0]   o_win_count
);

    assign o_win_count = (i_count >= CNT_W'(INST_WIN_BYTES)) ?
                         INST_LEN_W'(INST_WIN_BYTES) : i_count[INST_LEN_W-1:0];

    for (genvar g = 0; g < INST_WIN_BYTES; g++) begin : g_win
        logic [PTR_W-1:0] w_idx;
        logic             w_valid;
        // Pointer arithmetic wraps naturally because DEPTH is a power of two.
        assign w_idx   = i_head + PTR_W'(g);
        assign w_valid = INST_LEN_W'(g) < o_win_count;
        assign o_win_bytes[win_lsb(g) +: 8] = w_valid ? i_buf[{w_idx, 3'b000} +: 8] : 8'h00;
    end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Byte-granular instruction prefetch queue between a byte-wide instruction memory
// and the fetch/translate logic.
// Ports:
//   i_clk, i_resetn      clock, asynchronous active-low reset
//   i_redirect(_pc)      flush queue and restart fetch at the jump target
//   i_hold               suppress memory fill this cycle
//   i_consume(_len)      retire 1..6 bytes from the window head
//   o_instmem_addr       registered fetch PC; i_instmem_dataout is its byte
//   o_win_bytes/_count   oldest up-to-6 bytes and how many are valid
//   o_win_pc             address of o_win_bytes[7:0]
//   o_full               buffer holds DEPTH bytes
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_redirect,
    input  logic [31:0]           i_redirect_pc,
    input  logic                  i_hold,
    input  logic                  i_consume,
    input  logic [INST_LEN_W-1:0] i_consume_len,
    output logic [31:0]           o_instmem_addr,
    input  logic [7:0]            i_instmem_dataout,
    output logic [INST_WIN_W-1:0] o_win_bytes,
    output logic [INST_LEN_W-1:0] o_win_count,
    output logic [31:0]           o_win_pc,
    output logic                  o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_fetch_pc, r_win_pc;

    logic [PTR_W-1:0] w_head_d, w_tail_d;
    logic [CNT_W-1:0] w_count_d;
    logic [31:0]      w_fetch_pc_d, w_win_pc_d;
    logic             w_fill, w_take, w_len_ok;
    logic [DEPTH*8-1:0] w_buf;

    // Space is judged on the registered count only; bytes freed by a take
    // become fillable on the following cycle.
    assign w_fill   = !i_redirect && !i_hold && (r_count < CNT_W'(DEPTH));
    assign w_len_ok = (i_consume_len != '0) && (i_consume_len <= o_win_count);
    assign w_take   = i_consume && !i_redirect && w_len_ok;

    always_comb begin
        w_head_d     = r_head;
        w_tail_d     = r_tail;
        w_count_d    = r_count;
        w_fetch_pc_d = r_fetch_pc;
        w_win_pc_d   = r_win_pc;
        if (i_redirect) begin
            w_head_d     = '0;
            w_tail_d     = '0;
            w_count_d    = '0;
            w_fetch_pc_d = i_redirect_pc;
            w_win_pc_d   = i_redirect_pc;
        end else begin
            if (w_fill) begin
                w_tail_d     = r_tail + PTR_W'(1);
                w_fetch_pc_d = r_fetch_pc + 32'd1;
            end
            if (w_take) begin
                w_head_d   = r_head + PTR_W'(i_consume_len);
                w_win_pc_d = r_win_pc + 32'(i_consume_len);
            end
            w_count_d = r_count + CNT_W'(w_fill) - (w_take ? CNT_W'(i_consume_len) : '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_win_pc   <= RESET_PC;
        end else begin
            r_head     <= w_head_d;
            r_tail     <= w_tail_d;
            r_count    <= w_count_d;
            r_fetch_pc <= w_fetch_pc_d;
            r_win_pc   <= w_win_pc_d;
        end
    end

    // Storage needs no reset: bytes beyond count are masked in the window.
    always_ff @(posedge i_clk) begin
        if (w_fill) begin
            r_mem[r_tail] <= i_instmem_dataout;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_pack
        assign w_buf[g*8 +: 8] = r_mem[g];
    end

    inst_prefetch_queue_byte_window_rotate #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_rotate (
        .i_buf       (w_buf),
        .i_head      (r_head),
        .i_count     (r_count),
        .o_win_bytes (o_win_bytes),
        .o_win_count (o_win_count)
    );

    assign o_instmem_addr = r_fetch_pc;
    assign o_win_pc       = r_win_pc;
    assign o_full         = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
module tb_inst_prefetch_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hold;
    logic        consume;
    logic [2:0]  consume_len;
    logic [31:0] instmem_addr;
    logic [7:0]  instmem_dataout;
    logic [47:0] win_bytes;
    logic [2:0]  win_count;
    logic [31:0] win_pc;
    logic        full;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory model: each byte equals the low byte of its address.
    assign instmem_dataout = instmem_addr[7:0];

    inst_prefetch_queue #(
        .DEPTH    (8),
        .RESET_PC (32'h0)
    ) dut (
        .i_clk             (clk),
        .i_resetn          (resetn),
        .i_redirect        (redirect),
        .i_redirect_pc     (redirect_pc),
        .i_hold            (hold),
        .i_consume         (consume),
        .i_consume_len     (consume_len),
        .o_instmem_addr    (instmem_addr),
        .i_instmem_dataout (instmem_dataout),
        .o_win_bytes       (win_bytes),
        .o_win_count       (win_count),
        .o_win_pc          (win_pc),
        .o_full            (full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b1; redirect = 1'b0; redirect_pc = '0; hold = 1'b0;
        consume = 1'b0; consume_len = '0;
        #2 resetn = 1'b0;
        #1;
        total++; if (win_count !== 3'd0) begin bad++;
            $display("FAIL rst_count got=%0d exp=0", win_count); end
        total++; if (win_bytes !== 48'h0) begin bad++;
            $display("FAIL rst_bytes got=%h exp=0", win_bytes); end
        total++; if (full !== 1'b0) begin bad++;
            $display("FAIL rst_full got=%b exp=0", full); end
        total++; if (instmem_addr !== 32'h0) begin bad++;
            $display("FAIL rst_addr got=%h exp=0", instmem_addr); end
        total++; if (win_pc !== 32'h0) begin bad++;
            $display("FAIL rst_pc got=%h exp=0", win_pc); end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++; if (instmem_addr !== 32'(i)) begin bad++;
                $display("FAIL fill_addr[%0d] got=%h exp=%h", i, instmem_addr, 32'(i)); end
            if (i == 6) begin
                total++; if (win_count !== 3'd6) begin bad++;
                    $display("FAIL fill_count got=%0d exp=6", win_count); end
                total++; if (win_bytes !== 48'h050403020100) begin bad++;
                    $display("FAIL fill_bytes got=%h exp=050403020100", win_bytes); end
                total++; if (win_pc !== 32'h0) begin bad++;
                    $display("FAIL fill_pc got=%h exp=0", win_pc); end
                total++; if (full !== 1'b0) begin bad++;
                    $display("FAIL fill_notfull got=%b exp=0", full); end
            end
        end
        total++; if (full !== 1'b1) begin bad++;
            $display("FAIL fill_full got=%b exp=1", full); end
        tick(); tick();
        total++; if (instmem_addr !== 32'h8) begin bad++;
            $display("FAIL full_stable_addr got=%h exp=8", instmem_addr); end
        total++; if (full !== 1'b1) begin bad++;
            $display("FAIL full_stable got=%b exp=1", full); end
    endtask

    task automatic test_consume_full();
        consume = 1'b1; consume_len = 3'd2;
        tick();
        consume = 1'b0;
        total++; if (win_pc !== 32'h2) begin bad++;
            $display("FAIL cons_pc got=%h exp=2", win_pc); end
        total++; if (win_bytes !== 48'h070605040302) begin bad++;
            $display("FAIL cons_bytes got=%h exp=070605040302", win_bytes); end
        total++; if (full !== 1'b0) begin bad++;
            $display("FAIL cons_full got=%b exp=0", full); end
        total++; if (instmem_addr !== 32'h8) begin bad++;
            $display("FAIL cons_addr_hold got=%h exp=8", instmem_addr); end
        tick();
        total++; if (instmem_addr !== 32'h9) begin bad++;
            $display("FAIL refill_addr got=%h exp=9", instmem_addr); end
        tick();
        total++; if (full !== 1'b1) begin bad++;
            $display("FAIL refill_full got=%b exp=1", full); end
        consume = 1'b1; consume_len = 3'd6;
        tick();
        consume = 1'b0;
        total++; if (win_bytes !== 48'h000000000908) begin bad++;
            $display("FAIL refill_bytes got=%h exp=000000000908", win_bytes); end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_pc = 32'h100; consume = 1'b1; consume_len = 3'd4;
        tick();
        redirect = 1'b0; consume = 1'b0;
        total++; if (win_count !== 3'd0) begin bad++;
            $display("FAIL redir_count got=%0d exp=0", win_count); end
        total++; if (win_pc !== 32'h100) begin bad++;
            $display("FAIL redir_pc got=%h exp=100", win_pc); end
        total++; if (instmem_addr !== 32'h100) begin bad++;
            $display("FAIL redir_addr got=%h exp=100", instmem_addr); end
        tick();
        total++; if (win_count !== 3'd1) begin bad++;
            $display("FAIL redir_n2_count got=%0d exp=1", win_count); end
        total++; if (win_bytes !== 48'h0) begin bad++;
            $display("FAIL redir_n2_bytes got=%h exp=0", win_bytes); end
        tick();
        total++; if (win_bytes !== 48'h000000000100) begin bad++;
            $display("FAIL redir_n3_bytes got=%h exp=000000000100", win_bytes); end
    endtask

    task automatic test_illegal_len();
        logic [2:0]  lens [3];
        logic [47:0] exp_bytes [3];
        lens[0] = 3'd4; lens[1] = 3'd0; lens[2] = 3'd7;
        exp_bytes[0] = 48'h000003020100;
        exp_bytes[1] = 48'h000403020100;
        exp_bytes[2] = 48'h050403020100;
        tick();
        total++; if (win_count !== 3'd3) begin bad++;
            $display("FAIL ill_pre_count got=%0d exp=3", win_count); end
        for (int i = 0; i < 3; i++) begin
            consume = 1'b1; consume_len = lens[i];
            tick();
            total++; if (win_pc !== 32'h100) begin bad++;
                $display("FAIL ill_pc[%0d] got=%h exp=100", i, win_pc); end
            total++; if (win_bytes !== exp_bytes[i]) begin bad++;
                $display("FAIL ill_bytes[%0d] got=%h exp=%h", i, win_bytes, exp_bytes[i]); end
            total++; if (instmem_addr !== 32'h104 + 32'(i)) begin bad++;
                $display("FAIL ill_addr[%0d] got=%h exp=%h", i, instmem_addr,
                         32'h104 + 32'(i)); end
        end
        consume = 1'b0;
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        total++; if (instmem_addr !== 32'hFFFF_FFFE) begin bad++;
            $display("FAIL wrap_addr got=%h exp=fffffffe", instmem_addr); end
        for (int i = 0; i < 6; i++) tick();
        total++; if (win_bytes !== 48'h03020100FFFE) begin bad++;
            $display("FAIL wrap_bytes got=%h exp=03020100fffe", win_bytes); end
        total++; if (instmem_addr !== 32'h4) begin bad++;
            $display("FAIL wrap_fetch got=%h exp=4", instmem_addr); end
        consume = 1'b1; consume_len = 3'd3;
        tick();
        consume = 1'b0;
        total++; if (win_pc !== 32'h1) begin bad++;
            $display("FAIL wrap_pc got=%h exp=1", win_pc); end
        total++; if (win_bytes !== 48'h000004030201) begin bad++;
            $display("FAIL wrap_cons_bytes got=%h exp=000004030201", win_bytes); end
    endtask

    task automatic test_hold();
        logic [2:0]  exp_cnt [4];
        logic [31:0] exp_pc  [4];
        exp_cnt[0] = 3'd3; exp_cnt[1] = 3'd1; exp_cnt[2] = 3'd1; exp_cnt[3] = 3'd1;
        exp_pc[0] = 32'h3; exp_pc[1] = 32'h5; exp_pc[2] = 32'h5; exp_pc[3] = 32'h5;
        tick();
        total++; if (win_count !== 3'd5) begin bad++;
            $display("FAIL hold_pre_count got=%0d exp=5", win_count); end
        hold = 1'b1; consume = 1'b1; consume_len = 3'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (instmem_addr !== 32'h6) begin bad++;
                $display("FAIL hold_addr[%0d] got=%h exp=6", i, instmem_addr); end
            total++; if (win_count !== exp_cnt[i]) begin bad++;
                $display("FAIL hold_count[%0d] got=%0d exp=%0d", i, win_count, exp_cnt[i]); end
            total++; if (win_pc !== exp_pc[i]) begin bad++;
                $display("FAIL hold_pc[%0d] got=%h exp=%h", i, win_pc, exp_pc[i]); end
        end
        hold = 1'b0; consume = 1'b0;
        tick();
        total++; if (instmem_addr !== 32'h7) begin bad++;
            $display("FAIL unhold_addr got=%h exp=7", instmem_addr); end
        total++; if (win_bytes !== 48'h000000000605) begin bad++;
            $display("FAIL unhold_bytes got=%h exp=000000000605", win_bytes); end
    endtask

    task automatic test_async_reset();
        tick();
        #2 resetn = 1'b0;
        #1;
        total++; if (win_count !== 3'd0) begin bad++;
            $display("FAIL arst_count got=%0d exp=0", win_count); end
        total++; if (instmem_addr !== 32'h0) begin bad++;
            $display("FAIL arst_addr got=%h exp=0", instmem_addr); end
        total++; if (win_pc !== 32'h0) begin bad++;
            $display("FAIL arst_pc got=%h exp=0", win_pc); end
        resetn = 1'b1;
        tick();
        total++; if (win_bytes !== 48'h0) begin bad++;
            $display("FAIL arst_refill_bytes got=%h exp=0", win_bytes); end
        total++; if (win_count !== 3'd1) begin bad++;
            $display("FAIL arst_refill_count got=%0d exp=1", win_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_consume_full();
        test_redirect();
        test_illegal_len();
        test_wrap();
        test_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Byte-granular instruction prefetch queue that sits between the byte-wide instruction memory and the fetch/translate logic.
- Reads one byte per cycle from instruction memory at an internal fetch PC and holds the bytes in a circular buffer.
- Presents the oldest up-to-6 bytes as a 48-bit window, tagged with the PC of its first byte.
- The consumer retires a variable-length instruction (1-6 bytes) per cycle. A redirect from a taken jump flushes the queue and restarts fetch at the target.

Parameters:
DEPTH, 8, buffer capacity in bytes; power of two, >= 6
RESET_PC, 32'h0, fetch PC and window PC after reset

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
redirect  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  32  jump target
hold  in  1  suppress memory fill this cycle (consume still allowed)
consume  in  1  retire consume_len bytes from window head
consume_len  in  3  byte count to retire, legal 1..6
instmem_addr  out  32  byte address to instruction memory
instmem_dataout  in  8  byte at instmem_addr, same cycle (combinational read)
win_bytes  out  48  window; [7:0] = byte at win_pc, [15:8] = win_pc+1, ...; bytes at index >= win_count read as 0
win_count  out  3  valid window bytes = min(count, 6)
win_pc  out  32  address of win_bytes[7:0]
full  out  1  count == DEPTH

Behaviour:
- Reset (async, resetn low):
  - fetch_pc = win_pc = RESET_PC.
  - head = tail = 0, count = 0.
  - Outputs: win_count = 0, win_bytes = 0, full = 0, instmem_addr = RESET_PC.
  - Reset mid-operation discards all buffered bytes.
- instmem_addr = fetch_pc (registered; no combinational path from inputs).
- Fill:
  - fill = !redirect & !hold & (count < DEPTH), using the registered count (no same-cycle space from consume).
  - On fill: buf[tail] <= instmem_dataout, tail++ mod DEPTH, fetch_pc++ (32-bit wrap 0xFFFFFFFF -> 0).
- Consume:
  - take = consume & !redirect & (1 <= consume_len <= win_count).
  - On take: head += consume_len mod DEPTH, win_pc += consume_len (32-bit wrap).
  - Illegal length (0, 7, or > win_count) is ignored with no state change.
- Count update: count_next = count + fill - (take ? consume_len : 0). Simultaneous fill and take in one cycle is legal.
- Redirect has top priority:
  - head = tail = 0, count = 0, fetch_pc = win_pc = redirect_pc.
  - No fill and no take that cycle.
- Latency after redirect asserted in cycle N:
  - cycle N+1: instmem_addr = redirect_pc, win_count = 0.
  - cycle N+2: win_count = 1.
  - cycle N+7: win_count = 6, if hold stays low.
- Full: at count == DEPTH fetch stops and instmem_addr stays stable until a take frees space. Refill starts the cycle after the take.
- hold: fetch_pc and tail are frozen; the window and consume behave normally.
- Window: win_bytes byte i = buf[(head+i) mod DEPTH] for i < win_count, else 0. This is a combinational function of registered state.

Decomposition:
- Shared package constants:
  - INST_WIN_BYTES = 6.
  - INST_LEN_W = 3 (width of consume_len and win_count).
  - Window byte-order definition (byte 0 = lowest address), shared with the fetch/translate logic.
- Natural sub-module: byte_window_rotate. It is combinational and maps the DEPTH-byte buffer, head and count to the 48-bit masked window. The queue keeps all pointer, count and PC state.

Test Plan:
1. Memory model returns addr[7:0]; release reset with RESET_PC=0, hold=0, no consume -> instmem_addr increments 0,1,2,... Six cycles after release: win_count=6, win_bytes=48'h050403020100, win_pc=0. After 8 fills: full=1, instmem_addr=8 and stable.
2. Full queue (bytes 0x00..0x07), consume=1, consume_len=2 -> next cycle win_pc=2, win_bytes=48'h070605040302, full=0. One cycle later byte 0x08 is written and instmem_addr=9.
3. Redirect=1 to 0x100 in the same cycle as consume len 4 -> next cycle win_count=0, win_pc=0x100, instmem_addr=0x100, consume ignored. Two cycles later win_bytes[7:0]=0x00 (addr 0x100).
4. win_count=3, consume_len=4; then consume_len=0; then consume_len=7 -> head, win_pc and count unchanged each cycle; fill continues.
5. Redirect to 0xFFFFFFFE, fill 6 -> win_bytes=48'h03020100FFFE. Consume 3 -> win_pc=0x00000001 (wrap).
6. hold=1 for 4 cycles on a partly filled queue (count=5) while consuming 2 per cycle -> instmem_addr constant, count 5->3->1 then stays 1. Illegal len 2 is ignored. Release hold -> fill resumes at the frozen fetch_pc.
